bcd_display_driver: RTL

- Upstream stage of the 7-segment decoder. Accepts a 14-bit binary calculator result and converts it to four BCD digits with a sequential double-dabble FSM.
- Holds the digits in a display register and time-multiplexes them onto a 4-digit common-anode display.
- Outputs an active-low anode select plus the 4-bit digit code that feeds the segment decoder.

---
 rtl/display_pkg.sv | 31 +++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/bcd_display_driver.sv | 100 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and helpers
// for the BCD display driver slice.
package display_pkg;

    localparam int BIN_W   = 14;
    localparam int MAX_VAL = 9999;
    localparam int NDIG    = 4;
    localparam int BCD_W   = 4 * NDIG;

    localparam logic [NDIG-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    // double-dabble correction: +3 on every nibble >= 5
    function automatic logic [BCD_W-1:0] dd_adjust(
        input logic [BCD_W-1:0] b
    );
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter:
// one shift per cycle, BIN_W shifts, then LATCH.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [3:0] LAST = 4'(BIN_W - 1);

    conv_state_t      state, state_n;
    logic [BIN_W-1:0] sh, sh_n;
    logic [BCD_W-1:0] acc, acc_n;
    logic [3:0]       cnt, cnt_n;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // shift / accumulator / iteration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            sh  <= sh_n;
            acc <= acc_n;
            cnt <= cnt_n;
        end
    end

    // next-state and datapath control
    always_comb begin
        state_n = state;
        sh_n    = sh;
        acc_n   = acc;
        cnt_n   = cnt;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    sh_n    = bin;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                {acc_n, sh_n} = {dd_adjust(acc), sh} << 1;
                cnt_n = cnt + 4'd1;
                if (cnt == LAST)
                    state_n = LATCH;
            end
            LATCH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bcd = acc;

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display driver: saturating capture,
// conversion, display register and anode scanner.
module bcd_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [3:0]       digit
);

    localparam logic [BIN_W-1:0] SAT = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] WRAP = CNT_W'(REFRESH_DIV - 1);

    logic             accept;
    logic             done;
    logic             ovf_pend;
    logic [BIN_W-1:0] sat_val;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] disp;
    logic [CNT_W-1:0] rcnt;
    logic [1:0]       idx;
    logic [NDIG-1:0]  lz;

    assign accept  = load & ~busy;
    assign sat_val = (value > SAT) ? SAT : value;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (sat_val),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // remember overflow of the accepted value until LATCH
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_pend <= 1'b0;
        else if (accept)
            ovf_pend <= (value > SAT);
    end

    // display register and ovf update on LATCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp <= '0;
            ovf  <= 1'b0;
        end else if (done) begin
            disp <= bcd;
            ovf  <= ovf_pend;
        end
    end

    // refresh counter and scan index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == WRAP) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + CNT_W'(1);
        end
    end

    // leading-zero flags: nibble i and all above are zero
    always_comb begin
        lz = '0;
        lz[NDIG-1] = (disp[BCD_W-1 -: 4] == 4'd0);
        for (int i = NDIG - 2; i >= 1; i--)
            lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'd0);
    end

    // registered anode and digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an    <= ANODE_OFF;
            digit <= 4'd0;
        end else begin
            if (BLANK_LZ && lz[idx])
                an <= ANODE_OFF;
            else
                an <= ~(4'b0001 << idx);
            digit <= disp[{idx, 2'b00} +: 4];
        end
    end

endmodule
